// File: rtl/pixie_dma_scheduler.sv
// rtl/pixie_dma_scheduler.sv - CDP1861-style display DMA sequencer, RAM-port arbiter and INT/EFx timing
// Optional feature macro PIXIE_HW_REWIND_EN: rewind mem_addr so each row is replayed for its repeat lines.
module pixie_dma_scheduler #(
   parameter logic [15:0] BASE_ADDR      = 16'h0900,
   parameter int          BYTES_PER_LINE = 8,
   parameter int          LINE_REPEAT    = 4,
   parameter int          ROWS           = 32,
   parameter int          FIRST_LINE     = 64,
   parameter int          INT_LEAD       = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_enable,
   input  logic [1:0]  SC,
   input  logic        line_start,
   input  logic        frame_start,
   input  logic        disp_on,
   input  logic        disp_off,
   input  logic [7:0]  data_in,
   input  logic        cpu_req,
   output logic        cpu_gnt,
   output logic        DMAO,
   output logic        INT,
   output logic        EFx,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        row_wr,
   output logic [2:0]  row_wr_addr,
   output logic [7:0]  row_wr_data,
   output logic        underrun
);
   localparam int         RW        = $clog2(LINE_REPEAT);
   localparam logic [8:0] WIN_FIRST = 9'(FIRST_LINE);
   localparam logic [8:0] WIN_LAST  = 9'(FIRST_LINE + ROWS*LINE_REPEAT - 1);
   localparam logic [8:0] INT_LINE  = 9'(FIRST_LINE - INT_LEAD);
   localparam logic [8:0] EF_HEAD   = 9'(FIRST_LINE - 4);
   localparam logic [8:0] EF_TAIL   = 9'(FIRST_LINE + ROWS*LINE_REPEAT - 4);

   typedef enum logic [1:0] {IDLE, WAIT_LINE, REQ, LINE_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [8:0]      r_line;
   logic [7:0]      r_off;
   logic [2:0]      r_byte;
   logic [RW-1:0]   r_rep;
   logic            r_int;
   logic            r_efx;
   logic            r_row_wr;
   logic [2:0]      r_row_wr_addr;
   logic [7:0]      r_row_wr_data;
   logic            r_underrun;
   logic [8:0]      w_line_nxt;
   logic            w_off;
   logic            w_dma;
   logic            w_last_byte;
   logic            w_nxt_in_win;
   logic            w_new_line;
   logic            w_efx_zone;

   assign w_off        = disp_off & ~disp_on;
   assign w_dma        = clk_enable && (SC == 2'b10) && (r_state == REQ);
   assign w_last_byte  = (r_byte == 3'(BYTES_PER_LINE - 1));
   assign w_line_nxt   = r_line + 9'd1;
   assign w_nxt_in_win = (w_line_nxt >= WIN_FIRST) && (w_line_nxt <= WIN_LAST);
   assign w_new_line   = line_start && !frame_start;
   assign w_efx_zone   = ((r_line >= EF_HEAD) && (r_line < WIN_FIRST)) ||
                         ((r_line >= EF_TAIL) && (r_line <= WIN_LAST));

   assign mem_addr    = BASE_ADDR + {8'h00, r_off};
   assign INT         = r_int;
   assign EFx         = r_efx;
   assign row_wr      = r_row_wr;
   assign row_wr_addr = r_row_wr_addr;
   assign row_wr_data = r_row_wr_data;
   assign underrun    = r_underrun;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Video wins the RAM port; the grant is gated by reset so it reads low while held in reset.
   always_comb begin
      w_state_nxt = r_state;
      DMAO        = 1'b1;
      mem_rd      = w_dma;
      cpu_gnt     = reset_n && cpu_req && !w_dma;
      case (r_state)
         IDLE: begin
            if (disp_on) w_state_nxt = WAIT_LINE;
         end
         WAIT_LINE: begin
            if (w_off)                           w_state_nxt = IDLE;
            else if (w_new_line && w_nxt_in_win) w_state_nxt = REQ;
         end
         REQ: begin
            DMAO = 1'b0;
            if (w_off)                    w_state_nxt = IDLE;
            else if (frame_start)         w_state_nxt = WAIT_LINE;
            else if (line_start)          w_state_nxt = w_nxt_in_win ? REQ : IDLE;
            else if (w_dma && w_last_byte) w_state_nxt = LINE_DONE;
         end
         LINE_DONE: begin
            if (w_off || (r_line == WIN_LAST))   w_state_nxt = IDLE;
            else if (w_new_line && w_nxt_in_win) w_state_nxt = REQ;
            else                                 w_state_nxt = WAIT_LINE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         r_line <= '0;
      else if (frame_start) r_line <= '0;
      else if (line_start)  r_line <= w_line_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_off  <= '0;
         r_byte <= '0;
         r_rep  <= '0;
      end else if (frame_start) begin
         r_off  <= '0;
         r_byte <= '0;
         r_rep  <= '0;
      end else if (r_state == REQ) begin
         if (w_off || line_start) begin
            r_byte <= '0;
         end else if (w_dma) begin
            r_off  <= r_off + 8'd1;
            r_byte <= w_last_byte ? 3'd0 : r_byte + 3'd1;
         end
      end else if (r_state == LINE_DONE) begin
         if (int'(r_rep) + 1 < LINE_REPEAT) begin
            r_rep <= r_rep + RW'(1);
`ifdef PIXIE_HW_REWIND_EN
            r_off <= r_off - 8'(BYTES_PER_LINE);
`endif
         end else begin
            r_rep <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_row_wr      <= 1'b0;
         r_row_wr_addr <= '0;
         r_row_wr_data <= '0;
         r_underrun    <= 1'b0;
         r_efx         <= 1'b1;
         r_int         <= 1'b0;
      end else begin
         r_row_wr   <= w_dma;
         r_underrun <= (r_state == REQ) && w_new_line && !w_off;
         r_efx      <= !w_efx_zone;
         if (w_dma) begin
            r_row_wr_addr <= r_byte;
            r_row_wr_data <= data_in;
         end
         if (w_new_line && (w_line_nxt == INT_LINE) && (r_state != IDLE))
            r_int <= 1'b1;
         else if ((clk_enable && (SC == 2'b11)) || (r_line == WIN_FIRST))
            r_int <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pixie_dma_scheduler.sv
// tb/tb_pixie_dma_scheduler.sv - directed self-checking bench for pixie_dma_scheduler
module tb_pixie_dma_scheduler;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clk_enable = 1'b0;
   logic [1:0]  SC = 2'b00;
   logic        line_start = 1'b0;
   logic        frame_start = 1'b0;
   logic        disp_on = 1'b0;
   logic        disp_off = 1'b0;
   logic [7:0]  data_in;
   logic        cpu_req = 1'b1;
   logic        cpu_gnt, DMAO, INT, EFx, mem_rd, row_wr, underrun;
   logic [15:0] mem_addr;
   logic [2:0]  row_wr_addr;
   logic [7:0]  row_wr_data;

   int checks = 0;
   int failures = 0;

   logic        s_rd, s_gnt, s_dmao, s_int, s_efx, s_row_wr, s_under;
   logic [15:0] s_addr;
   logic [2:0]  s_wa;
   logic [7:0]  s_wd;

   int n_rd, n_wr, n_gnt_lo, n_ovl, n_dmao_lo, n_under, addr_err, wr_err, j, last_j;
   logic [15:0] exp_a, a_first, a_row4, a_last;
   logic        efx_at [0:199];
   logic        int61, int62a, int62b, int62c, ef60a, ef60b, int63, int64;
   int          seg_rd, seg_under;
   logic [15:0] seg_first;
   logic        seg_first_seen;
   logic [2:0]  seg_first_wa;
   logic        seg_first_wa_seen;

   always #5 clk = ~clk;
   assign data_in = mem_addr[7:0] ^ 8'hA5;

   pixie_dma_scheduler dut (
      .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .SC(SC),
      .line_start(line_start), .frame_start(frame_start), .disp_on(disp_on),
      .disp_off(disp_off), .data_in(data_in), .cpu_req(cpu_req), .cpu_gnt(cpu_gnt),
      .DMAO(DMAO), .INT(INT), .EFx(EFx), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .row_wr(row_wr), .row_wr_addr(row_wr_addr), .row_wr_data(row_wr_data),
      .underrun(underrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts and ends at posedge+1; samples outputs with this cycle's inputs applied.
   task automatic cyc(input logic ls, input logic fs, input logic ce, input logic [1:0] sc);
      line_start = ls; frame_start = fs; clk_enable = ce; SC = sc;
      #1;
      s_rd = mem_rd; s_addr = mem_addr; s_gnt = cpu_gnt; s_dmao = DMAO; s_int = INT;
      s_efx = EFx; s_row_wr = row_wr; s_wa = row_wr_addr; s_wd = row_wr_data; s_under = underrun;
      @(posedge clk); #1;
      line_start = 1'b0; frame_start = 1'b0; clk_enable = 1'b0; disp_on = 1'b0; disp_off = 1'b0;
   endtask

   task automatic seg(input int n, input logic ce, input logic [1:0] sc);
      for (int k = 0; k < n; k++) begin
         cyc(1'b0, 1'b0, ce, sc);
         if (s_row_wr && !seg_first_wa_seen) begin seg_first_wa = s_wa; seg_first_wa_seen = 1'b1; end
         if (s_rd) begin
            if (!seg_first_seen) begin seg_first = s_addr; seg_first_seen = 1'b1; end
            seg_rd++;
         end
         if (s_under) seg_under++;
      end
   endtask

   task automatic seg_clear();
      seg_rd = 0; seg_under = 0; seg_first_seen = 1'b0; seg_first_wa_seen = 1'b0;
      seg_first = '0; seg_first_wa = '0;
   endtask

   task automatic fast_lines(input int last);
      for (int ln = 1; ln <= last; ln++) begin
         cyc(1'b1, 1'b0, 1'b0, 2'b00);
         cyc(1'b0, 1'b0, 1'b0, 2'b00);
         if (ln == 63) int63 = s_int;
      end
   endtask

   function automatic int model_off(input int ln, input int jj);
`ifdef PIXIE_HW_REWIND_EN
      return (((ln - 64) / 4) * 8 + jj) & 255;
`else
      return ((ln - 64) * 8 + jj) & 255;
`endif
   endfunction

   initial begin
      // reset values, cpu_req held high during reset
      @(posedge clk); @(posedge clk); #1;
      chk("rst_dmao", DMAO, 1); chk("rst_int", INT, 0); chk("rst_efx", EFx, 1);
      chk("rst_gnt", cpu_gnt, 0); chk("rst_rd", mem_rd, 0); chk("rst_row_wr", row_wr, 0);
      chk("rst_wa", row_wr_addr, 0); chk("rst_wd", row_wr_data, 0); chk("rst_under", underrun, 0);
      chk("rst_addr", mem_addr, 16'h0900);
      reset_n = 1'b1;

      // full frame, SC=10 on every clk_enable, cpu_req high throughout
      n_rd = 0; n_wr = 0; n_gnt_lo = 0; n_ovl = 0; n_dmao_lo = 0; n_under = 0;
      addr_err = 0; wr_err = 0; last_j = 0; a_first = '0; a_row4 = '0; a_last = '0;
      disp_on = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 2'b00);
      for (int ln = 1; ln <= 199; ln++) begin
         j = 0;
         for (int c = 0; c < 16; c++) begin
            cyc(c == 0, 1'b0, c != 0, (ln == 62 && c == 5) ? 2'b11 : 2'b10);
            if (s_row_wr) begin
               n_wr++;
               if (s_wa !== 3'(last_j) || s_wd !== (a_last[7:0] ^ 8'hA5)) wr_err++;
            end
            if (s_rd) begin
               exp_a = 16'h0900 + 16'(model_off(ln, j));
               if (s_addr !== exp_a) addr_err++;
               if (ln == 64 && j == 0) a_first = s_addr;
               if (ln == 68 && j == 0) a_row4 = s_addr;
               a_last = s_addr; last_j = j; n_rd++; j++;
            end
            if (!s_gnt) n_gnt_lo++;
            if (s_gnt && s_rd) n_ovl++;
            if (!s_dmao) n_dmao_lo++;
            if (s_under) n_under++;
            if (ln == 61 && c == 8) int61 = s_int;
            if (ln == 62 && c == 1) int62a = s_int;
            if (ln == 62 && c == 4) int62b = s_int;
            if (ln == 62 && c == 7) int62c = s_int;
            if (ln == 60 && c == 1) ef60a = s_efx;
            if (ln == 60 && c == 2) ef60b = s_efx;
            if (c == 15) efx_at[ln] = s_efx;
         end
      end
      chk("frame_rd_count", n_rd, 1024);
      chk("frame_addr_errs", addr_err, 0);
      chk("frame_wr_count", n_wr, 1024);
      chk("frame_wr_errs", wr_err, 0);
      chk("first_read", a_first, 16'h0900);
`ifdef PIXIE_HW_REWIND_EN
      chk("row4_read", a_row4, 16'h0908);
`else
      chk("row4_read", a_row4, 16'h0920);
`endif
      chk("last_read", a_last, 16'h09FF);
      chk("gnt_low_cycles", n_gnt_lo, 1024);
      chk("gnt_rd_overlap", n_ovl, 0);
      chk("dmao_low_cycles", n_dmao_lo, 1024);
      chk("frame_underruns", n_under, 0);
      chk("int_line61", int61, 0);
      chk("int_line62_set", int62a, 1);
      chk("int_before_ack", int62b, 1);
      chk("int_after_ack", int62c, 0);
      chk("efx_lag_line60", ef60a, 1);
      chk("efx_line60_c2", ef60b, 0);
      chk("efx_59", efx_at[59], 1); chk("efx_60", efx_at[60], 0); chk("efx_63", efx_at[63], 0);
      chk("efx_64", efx_at[64], 1); chk("efx_187", efx_at[187], 1); chk("efx_188", efx_at[188], 0);
      chk("efx_191", efx_at[191], 0); chk("efx_192", efx_at[192], 1);

      // underrun: 5 transfers on line 64, then line 65 restarts
      cpu_req = 1'b0;
      disp_on = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 2'b00);
      fast_lines(63);
      chk("int_line63_no_ack", int63, 1);
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      seg_clear(); seg(5, 1'b1, 2'b10); seg(7, 1'b1, 2'b01);
      int64 = INT;
      chk("int_cleared_line64", int64, 0);
      chk("short_line_reads", seg_rd, 5);
      chk("short_line_no_under", seg_under, 0);
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      seg_clear(); seg(12, 1'b1, 2'b10);
      chk("underrun_pulses", seg_under, 1);
      chk("restart_addr", seg_first, 16'h0905);
      chk("restart_wa", seg_first_wa, 0);
      chk("restart_reads", seg_rd, 8);

      // disp_off after 3 transfers
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      seg_clear(); seg(3, 1'b1, 2'b10);
      disp_off = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 2'b00);
      chk("dmao_before_off", s_dmao, 0);
      seg_clear(); seg(6, 1'b1, 2'b10);
      chk("dmao_after_off", s_dmao, 1);
      chk("reads_after_off", seg_rd, 0);
`ifdef PIXIE_HW_REWIND_EN
      chk("addr_after_off", mem_addr, 16'h0908);
`else
      chk("addr_after_off", mem_addr, 16'h0910);
`endif
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      seg_clear(); seg(6, 1'b1, 2'b10);
      chk("reads_next_line_idle", seg_rd, 0);
      disp_on = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 2'b00);
      chk("addr_after_frame_start", mem_addr, 16'h0900);
      chk("dmao_wait_line", DMAO, 1);

      // asynchronous reset in the middle of a DMA cycle
      fast_lines(63);
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      cyc(1'b0, 1'b0, 1'b1, 2'b10);
      cyc(1'b0, 1'b0, 1'b1, 2'b10);
      cpu_req = 1'b1; clk_enable = 1'b1; SC = 2'b10;
      #1;
      chk("pre_rst_rd", mem_rd, 1);
      chk("pre_rst_addr", mem_addr, 16'h0902);
      chk("pre_rst_dmao", DMAO, 0);
      reset_n = 1'b0;
      #1;
      chk("async_rst_dmao", DMAO, 1);
      chk("async_rst_rd", mem_rd, 0);
      chk("async_rst_addr", mem_addr, 16'h0900);
      chk("async_rst_gnt", cpu_gnt, 0);
      chk("async_rst_row_wr", row_wr, 0);
      clk_enable = 1'b0; SC = 2'b00; cpu_req = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      cyc(1'b1, 1'b0, 1'b1, 2'b10);
      cyc(1'b0, 1'b0, 1'b1, 2'b10);
      chk("post_rst_idle_rd", s_rd, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
